// File: rtl/button_pkg.sv
// Shared types and helpers for the button event controller.
// Macro BUTTON_DOUBLE_PRESS_EN adds the GAP state used for double-press detection.
package button_pkg;

  typedef enum logic [1:0] {
    EVT_NONE   = 2'd0,
    EVT_SHORT  = 2'd1,
    EVT_LONG   = 2'd2,
    EVT_DOUBLE = 2'd3
  } evt_type_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TIMING = 2'd1,
    ST_HELD   = 2'd2
`ifdef BUTTON_DOUBLE_PRESS_EN
    ,
    ST_GAP    = 2'd3
`endif
  } press_state_t;

  // Duration in whole clock cycles, never less than one.
  function automatic int cycles(input int ns, input int period);
    int c;
    c = ns / period;
    if (c < 1) begin
      return 1;
    end else begin
      return c;
    end
  endfunction

  function automatic int max_int(input int a, input int b);
    if (a > b) begin
      return a;
    end else begin
      return b;
    end
  endfunction

endpackage

// File: rtl/button_event_ctrl_press_timer.sv
// Shared saturating press/gap counter; clr and en asserted together load 1.
// The at_gap flag exists only when BUTTON_DOUBLE_PRESS_EN is defined.
module press_timer
  import button_pkg::*;
#(
  parameter int LIMIT     = 25,
  parameter int GAP_LIMIT = 15,
  localparam int MAX_CNT  = max_int(LIMIT, GAP_LIMIT),
  localparam int CNT_W    = $clog2(MAX_CNT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic at_limit
`ifdef BUTTON_DOUBLE_PRESS_EN
  ,
  output logic at_gap
`endif
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] base_s;

  // Next count: optional clear, then saturating increment.
  always_comb begin
    base_s = cnt_q;
    cnt_d  = cnt_q;
    if (clr) begin
      base_s = '0;
    end else begin
      base_s = cnt_q;
    end
    if (en && (base_s != CNT_W'(MAX_CNT))) begin
      cnt_d = base_s + CNT_W'(1);
    end else begin
      cnt_d = base_s;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Flags look one count ahead so the event lands on the threshold sample.
  assign at_limit = (cnt_q >= CNT_W'(LIMIT - 1));
`ifdef BUTTON_DOUBLE_PRESS_EN
  assign at_gap   = (cnt_q >= CNT_W'(GAP_LIMIT - 1));
`endif

endmodule

// File: rtl/button_event_ctrl.sv
// Classifies presses on NUM_BUTTONS buttons as short/long using one shared timer.
// Define BUTTON_DOUBLE_PRESS_EN to add double-press detection via a release gap.
module button_event_ctrl
  import button_pkg::*;
#(
  parameter int CLK_PERIOD_ns  = 20,
  parameter int PRESS_TIMER_ns = 500,
  parameter int DOUBLE_GAP_ns  = 300,
  parameter int NUM_BUTTONS    = 4,
  localparam int ID_W = (NUM_BUTTONS > 1) ? $clog2(NUM_BUTTONS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_BUTTONS-1:0] in,
  output logic                   evt_valid,
  output logic [1:0]             evt_type,
  output logic [ID_W-1:0]        evt_id,
  output logic                   busy
);

  localparam int LIMIT     = cycles(PRESS_TIMER_ns, CLK_PERIOD_ns);
  localparam int GAP_LIMIT = cycles(DOUBLE_GAP_ns, CLK_PERIOD_ns);

  press_state_t           state_q, state_d;
  logic [ID_W-1:0]        id_q, id_d;
  logic                   evt_valid_q, evt_valid_d;
  evt_type_t              evt_type_q, evt_type_d;
  logic [ID_W-1:0]        evt_id_q, evt_id_d;
  logic                   busy_q, busy_d;
  logic [NUM_BUTTONS-1:0] in_dly_q;

  logic [NUM_BUTTONS-1:0] rise_s;
  logic                   grant_found_s;
  logic [ID_W-1:0]        grant_id_s;
  logic                   granted_lvl_s;
  logic                   tmr_clr_s;
  logic                   tmr_en_s;
  logic                   at_limit_s;
`ifdef BUTTON_DOUBLE_PRESS_EN
  logic                   at_gap_s;
`endif

  press_timer #(
    .LIMIT     (LIMIT),
    .GAP_LIMIT (GAP_LIMIT)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clr      (tmr_clr_s),
    .en       (tmr_en_s),
    .at_limit (at_limit_s)
`ifdef BUTTON_DOUBLE_PRESS_EN
    ,
    .at_gap   (at_gap_s)
`endif
  );

  assign rise_s        = in & ~in_dly_q;
  assign granted_lvl_s = in[id_q];

  // Fixed-priority pick: scanning downward leaves the lowest rising index.
  always_comb begin
    grant_found_s = 1'b0;
    grant_id_s    = '0;
    for (int i = NUM_BUTTONS - 1; i >= 0; i--) begin
      if (rise_s[i]) begin
        grant_found_s = 1'b1;
        grant_id_s    = ID_W'(i);
      end else begin
        grant_found_s = grant_found_s;
        grant_id_s    = grant_id_s;
      end
    end
  end

  // Press FSM next-state, timer control and event generation.
  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    evt_valid_d = 1'b0;
    evt_type_d  = EVT_NONE;
    evt_id_d    = '0;
    tmr_clr_s   = 1'b0;
    tmr_en_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tmr_clr_s = 1'b1;
        if (grant_found_s) begin
          id_d     = grant_id_s;
          tmr_en_s = 1'b1;
          state_d  = ST_TIMING;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_TIMING: begin
        if (granted_lvl_s) begin
          tmr_en_s = 1'b1;
          if (at_limit_s) begin
            evt_valid_d = 1'b1;
            evt_type_d  = EVT_LONG;
            evt_id_d    = id_q;
            state_d     = ST_HELD;
          end else begin
            state_d     = ST_TIMING;
          end
        end else begin
          tmr_clr_s = 1'b1;
`ifdef BUTTON_DOUBLE_PRESS_EN
          state_d   = ST_GAP;
`else
          evt_valid_d = 1'b1;
          evt_type_d  = EVT_SHORT;
          evt_id_d    = id_q;
          state_d     = ST_IDLE;
`endif
        end
      end
      ST_HELD: begin
        if (!granted_lvl_s) begin
          tmr_clr_s = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          state_d   = ST_HELD;
        end
      end
`ifdef BUTTON_DOUBLE_PRESS_EN
      ST_GAP: begin
        tmr_en_s = 1'b1;
        if (rise_s[id_q]) begin
          evt_valid_d = 1'b1;
          evt_type_d  = EVT_DOUBLE;
          evt_id_d    = id_q;
          state_d     = ST_HELD;
        end else if (at_gap_s) begin
          evt_valid_d = 1'b1;
          evt_type_d  = EVT_SHORT;
          evt_id_d    = id_q;
          tmr_clr_s   = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          state_d     = ST_GAP;
        end
      end
`endif
      default: begin
        tmr_clr_s = 1'b1;
        state_d   = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // FSM, event and edge-detect registers; in_dly resets high so held buttons need a fresh press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      id_q        <= '0;
      evt_valid_q <= 1'b0;
      evt_type_q  <= EVT_NONE;
      evt_id_q    <= '0;
      busy_q      <= 1'b0;
      in_dly_q    <= '1;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      evt_valid_q <= evt_valid_d;
      evt_type_q  <= evt_type_d;
      evt_id_q    <= evt_id_d;
      busy_q      <= busy_d;
      in_dly_q    <= in;
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_type  = evt_type_q;
  assign evt_id    = evt_id_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_button_event_ctrl.sv
// Directed scoreboard bench for button_event_ctrl at default parameters.
// Double-press scenarios run only when BUTTON_DOUBLE_PRESS_EN is defined.
module tb_button_event_ctrl;
  import button_pkg::*;

  localparam int LIMIT     = 25;
  localparam int GAP_LIMIT = 15;
`ifdef BUTTON_DOUBLE_PRESS_EN
  localparam int  SHORT_LAT = 1 + GAP_LIMIT;
  localparam logic BUSY_AFTER_REL = 1'b1;
`else
  localparam int  SHORT_LAT = 1;
  localparam logic BUSY_AFTER_REL = 1'b0;
`endif

  typedef struct {
    logic [1:0] t;
    logic [1:0] id;
    int         cyc;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [3:0] btn;
  logic       evt_valid;
  logic [1:0] evt_type;
  logic [1:0] evt_id;
  logic       busy;

  exp_t exp_q[$];
  int   n_checks;
  int   n_pass;
  int   n_fail;
  int   cyc;
  logic prev_valid;

  button_event_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in        (btn),
    .evt_valid (evt_valid),
    .evt_type  (evt_type),
    .evt_id    (evt_id),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic push(input logic [1:0] t, input logic [1:0] id, input int at);
    exp_t e;
    e.t = t;
    e.id = id;
    e.cyc = at;
    exp_q.push_back(e);
  endtask

  // Called once per cycle at the falling edge: compare outputs against the scoreboard.
  task automatic sample();
    exp_t e;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      check("evt_missing_at", cyc, exp_q[0].cyc);
      void'(exp_q.pop_front());
    end
    if (evt_valid === 1'b1) begin
      check("evt_back_to_back", prev_valid, 0);
      if (exp_q.size() == 0) begin
        check("evt_unexpected_valid", evt_valid, 0);
      end else begin
        e = exp_q.pop_front();
        check("evt_cycle", cyc, e.cyc);
        check("evt_type", evt_type, e.t);
        check("evt_id", evt_id, e.id);
      end
    end else begin
      check("idle_valid", evt_valid, 0);
      check("idle_type", evt_type, 0);
      check("idle_id", evt_id, 0);
    end
    prev_valid = evt_valid;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      sample();
      @(posedge clk);
      cyc++;
      #1;
    end
  endtask

  initial begin
    int c;
    int c2;
    n_checks = 0;
    n_pass = 0;
    n_fail = 0;
    cyc = 0;
    prev_valid = 1'b0;
    rst = 1'b1;
    btn = 4'b0000;
    tick(2);
    check("rst_evt_valid", evt_valid, 0);
    check("rst_evt_type", evt_type, 0);
    check("rst_evt_id", evt_id, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    tick(3);

    // Long press of button 2.
    c = cyc;
    btn[2] = 1'b1;
    push(EVT_LONG, 2'd2, c + LIMIT);
    tick(1);
    check("long_busy_after_grant", busy, 1);
    tick(39);
    check("long_busy_while_held", busy, 1);
    btn[2] = 1'b0;
    tick(1);
    check("long_busy_after_release", busy, 0);
    tick(20);

    // Short press of button 0.
    c = cyc;
    btn[0] = 1'b1;
    tick(10);
    btn[0] = 1'b0;
    push(EVT_SHORT, 2'd0, c + 10 + SHORT_LAT);
    tick(1);
    check("short_busy_after_release", busy, BUSY_AFTER_REL);
    tick(30);

    // Buttons 1 and 3 together: lowest index wins.
    c = cyc;
    btn = 4'b1010;
    tick(5);
    btn = 4'b0000;
    push(EVT_SHORT, 2'd1, c + 5 + SHORT_LAT);
    tick(30);

    // Button 1 pressed while button 0 is being timed is dropped.
    c = cyc;
    btn[0] = 1'b1;
    push(EVT_LONG, 2'd0, c + LIMIT);
    tick(5);
    btn[1] = 1'b1;
    tick(7);
    btn[1] = 1'b0;
    tick(18);
    btn[0] = 1'b0;
    tick(5);
    c2 = cyc;
    btn[1] = 1'b1;
    tick(4);
    btn[1] = 1'b0;
    push(EVT_SHORT, 2'd1, c2 + 4 + SHORT_LAT);
    tick(30);

    // Reset mid-press: no event, held button not re-granted.
    c = cyc;
    btn[2] = 1'b1;
    tick(10);
    check("midrst_busy_before", busy, 1);
    rst = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_evt_valid", evt_valid, 0);
    tick(1);
    rst = 1'b0;
    tick(29);
    check("midrst_no_regrant", busy, 0);
    btn[2] = 1'b0;
    tick(3);
    c2 = cyc;
    btn[2] = 1'b1;
    tick(3);
    btn[2] = 1'b0;
    push(EVT_SHORT, 2'd2, c2 + 3 + SHORT_LAT);
    tick(30);

`ifdef BUTTON_DOUBLE_PRESS_EN
    // Double press: second rise inside the gap window.
    c = cyc;
    btn[3] = 1'b1;
    tick(5);
    btn[3] = 1'b0;
    tick(5);
    btn[3] = 1'b1;
    push(EVT_DOUBLE, 2'd3, c + 11);
    tick(5);
    btn[3] = 1'b0;
    tick(30);

    // Gap too long: two separate shorts.
    c = cyc;
    btn[3] = 1'b1;
    tick(5);
    btn[3] = 1'b0;
    push(EVT_SHORT, 2'd3, c + 6 + GAP_LIMIT);
    tick(20);
    btn[3] = 1'b1;
    push(EVT_SHORT, 2'd3, c + 25 + 6 + GAP_LIMIT);
    tick(5);
    btn[3] = 1'b0;
    tick(30);
`endif

    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/button_event_ctrl.md
# button_event_ctrl

Shares one press-duration timer between `NUM_BUTTONS` debounced push-buttons and classifies each press as short, long or (optionally) double. It sits between the per-button input conditioning and the top-level mode/menu logic, replacing one `long_press` instance per button. Events leave as single-cycle pulses tagged with the originating button index.

## Interface
- `CLK_PERIOD_ns`, 20: clock period in ns.
- `PRESS_TIMER_ns`, 500: long-press threshold in ns.
- `DOUBLE_GAP_ns`, 300: maximum release-to-repress gap for a double press, in ns. Used only with `DOUBLE_PRESS_EN`.
- `NUM_BUTTONS`, 4: number of buttons, ≥ 2.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in`  in  `NUM_BUTTONS`  debounced, synchronised button levels; 1 = pressed.
- `evt_valid`  out  1  one-cycle event strobe.
- `evt_type`  out  2  event type: 0 none, 1 short, 2 long, 3 double. Valid only while `evt_valid` = 1, otherwise 0.
- `evt_id`  out  `ID_W` = max(1, $clog2(`NUM_BUTTONS`))  button index of the event. Otherwise 0.
- `busy`  out  1  high whenever the timer is granted (FSM not in IDLE).

## Operation
- Derived constants:
  - `LIMIT` = `PRESS_TIMER_ns` / `CLK_PERIOD_ns`, integer division, clamped to ≥ 1.
  - `GAP_LIMIT` = `DOUBLE_GAP_ns` / `CLK_PERIOD_ns`, clamped to ≥ 1.
- Counter width is $clog2(max(`LIMIT`, `GAP_LIMIT`) + 1). The counter saturates and never wraps.
- Edge detect: register `in_d`. A rising edge is `in & ~in_d`. `in_d` resets to all-ones, so any button held through reset needs a fresh press.
- Arbitration: grants happen only in IDLE, on a rising edge. Fixed priority, lowest index wins. Other simultaneous edges, and all edges while `busy`, are dropped. No queueing.
- FSM states:
  - IDLE: on a rising edge, latch `id`, set `cnt` = 1, go to TIMING.
  - TIMING: granted button sampled high → `cnt`++. If `cnt` + 1 = `LIMIT`, emit long and go to HELD.
  - TIMING: granted button sampled low (`cnt` < `LIMIT`) → emit short and go to IDLE. With the macro, go to GAP instead, with `cnt` = 0.
  - HELD: wait for the granted button to go low, then go to IDLE. Nothing is emitted on release.
  - GAP (macro only): `cnt`++ each cycle.
    - Rising edge of the same button → emit double, go to HELD.
    - `cnt` reaches `GAP_LIMIT` → emit short, go to IDLE.
    - Edges on other buttons are ignored.
- Reset mid-operation: FSM goes to IDLE, counter 0, event cleared immediately (asynchronous). No event is generated for the interrupted press.

## Timing
- Reset values: `evt_valid` 0, `evt_type` 0, `evt_id` 0, `busy` 0. State IDLE, `cnt` 0, `in_d` all-ones.
- Edge k is the first clock edge that samples the button high.
- `busy` goes high after edge k.
- Long press (button held): `evt_valid` is high for exactly the cycle after edge k + `LIMIT` − 1, i.e. the `LIMIT`-th high sample. With defaults, the 25th high sample.
- Short press (no macro): `evt_valid` is high for the cycle after the first low sample. `busy` drops in that same cycle.
- Short press with macro: the short event is delayed by `GAP_LIMIT` cycles after the release sample.
- Events are registered outputs: never two consecutive `evt_valid` cycles, and no combinational path from `in`.

## Configuration
- `BUTTON_DOUBLE_PRESS_EN` defined: GAP state and the `DOUBLE_GAP_ns` logic are compiled in. `evt_type` = 3 is reachable, and short events carry the `GAP_LIMIT` latency.
- Not defined: GAP is absent and the parameter is unused. A release in TIMING emits short directly, and `evt_type` is never 3.

## Structure
- Package `button_pkg`:
  - `evt_type_t` enum: `EVT_NONE`, `EVT_SHORT`, `EVT_LONG`, `EVT_DOUBLE`.
  - FSM state enum `press_state_t`.
  - Function `cycles(ns, period)` returning the clamped cycle count.
- Sub-module `press_timer`: the shared saturating counter, with clear/enable inputs and `at_limit`/`at_gap` flags.
- The FSM and arbiter stay in `button_event_ctrl`.

## Test plan
- Defaults (`LIMIT` = 25): hold button 2 for 40 cycles → one pulse, type 2, id 2, after the 25th high sample. No pulse on release. `busy` drops after release.
- Hold button 0 for 10 cycles, no macro → one pulse, type 1, id 0, one cycle after the release sample.
- Buttons 1 and 3 rise on the same edge, both held 5 cycles → exactly one short event, id 1. Button 3 produces nothing.
- Press button 0 for 30 cycles; press button 1 at cycle 5 and release at cycle 12 → only the long event for id 0. A later fresh press of button 1 is accepted normally.
- Assert `rst` for 1 cycle at cycle 10 of a button-2 hold that continues to cycle 40 → outputs 0 immediately, no event for that press. A new press after release is granted.
- With the macro (`GAP_LIMIT` = 15): button 3 presses of 5 cycles each, 5 cycles apart → a single type-3 event at the second rising edge, no short.
- With the macro, same stimulus but a 20-cycle gap → two type-1 events, each 15 cycles after its release.
